// File: rtl/e1_pkg.sv
// -----------------------------------------------------------------------------
// e1_pkg
// Shared types and constants for the E1 transmit line interface.
//   sym_t     : 2-bit line symbol carried through the HDB3 pipeline
//   SYM_*     : symbol encodings (ZERO must stay all-zero; the pipeline resets to it)
//   POL_*     : polarity of the most recent mark on the line
//   CNT_W     : width of the bit-timing and pulse-width counters
// -----------------------------------------------------------------------------
package e1_pkg;

   typedef logic [1:0] sym_t;

   localparam sym_t SYM_ZERO = 2'd0;   // space, no pulse
   localparam sym_t SYM_ONE  = 2'd1;   // data mark, alternates polarity
   localparam sym_t SYM_B    = 2'd2;   // HDB3 balancing pulse, obeys AMI alternation
   localparam sym_t SYM_V    = 2'd3;   // HDB3 violation, repeats previous polarity

   localparam logic POL_NEG = 1'b0;
   localparam logic POL_POS = 1'b1;

   localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/e1_tx_hdb3.sv
// -----------------------------------------------------------------------------
// e1_tx_hdb3
// Four-symbol line-coding pipeline. On every bit tick the oldest symbol is
// emitted, the pipeline shifts and the new symbol enters at the tail. With
// HDB3 enabled, a pipeline holding four ZEROs after the shift is rewritten to
// 000V or B00V so the line never carries four consecutive spaces.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   tick_i       : one-cycle bit strobe; all state advances only on it
//   sym_i        : symbol entering the pipeline this tick (ONE or ZERO)
//   hdb3_en_i    : substitution enable, sampled on the tick
//   pulse_p_o    : emitted symbol is a positive pulse (valid only with tick_i)
//   pulse_n_o    : emitted symbol is a negative pulse (valid only with tick_i)
// -----------------------------------------------------------------------------
module e1_tx_hdb3
   import e1_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  sym_t sym_i,
   input  logic hdb3_en_i,
   output logic pulse_p_o,
   output logic pulse_n_o
);

   // pipe[3] is the head (next symbol on the line), pipe[0] the newest.
   sym_t [3:0] pipe_q, pipe_d;
   logic       last_pol_q, last_pol_d;
   // Parity of marks (ONE/B) emitted since the last V; picks 000V vs B00V.
   logic       v_par_q, v_par_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      pipe_d     = pipe_q;
      last_pol_d = last_pol_q;
      v_par_d    = v_par_q;
      pulse_p_o  = 1'b0;
      pulse_n_o  = 1'b0;

      if (tick_i) begin
         case (pipe_q[3])
            SYM_ONE, SYM_B: begin
               last_pol_d = ~last_pol_q;
               v_par_d    = ~v_par_q;
               pulse_p_o  = (last_pol_d == POL_POS);
               pulse_n_o  = (last_pol_d == POL_NEG);
            end
            SYM_V: begin
               v_par_d   = 1'b0;
               pulse_p_o = (last_pol_q == POL_POS);
               pulse_n_o = (last_pol_q == POL_NEG);
            end
            default: ;
         endcase

         pipe_d = {pipe_q[2:0], sym_i};

         // Decision uses the parity that already includes this tick's emission.
         if (hdb3_en_i && (pipe_d == {4{SYM_ZERO}})) begin
            pipe_d[0] = SYM_V;
            pipe_d[3] = v_par_d ? SYM_ZERO : SYM_B;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: the short symbol pipeline is reset deliberately: the line must
         // start from a known all-space state with defined polarity.
         pipe_q     <= {4{SYM_ZERO}};
         last_pol_q <= POL_NEG;
         v_par_q    <= 1'b0;
      end else begin
         pipe_q     <= pipe_d;
         last_pol_q <= last_pol_d;
         v_par_q    <= v_par_d;
      end
   end

endmodule

// File: rtl/e1_tx_liu.sv
// -----------------------------------------------------------------------------
// e1_tx_liu
// E1 transmit line sequencer. Generates the bit tick, pulls one framed bit per
// tick from upstream (valid/ack), substitutes a ONE when upstream is empty
// (AIS fill), runs AMI/HDB3 coding and shapes RZ pulses on tx_hi / tx_lo.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : next bit to transmit, held stable while in_valid
//   in_valid    : in_data is valid
//   in_ack      : bit consumed this cycle (tick with in_valid)
//   cfg_enable  : 0 idles the line and holds the bit timer at DIV-1
//   cfg_hdb3    : 1 HDB3, 0 plain AMI; sampled on each tick
//   tx_hi/tx_lo : registered positive / negative pulse requests to the pads
//   underrun    : tick with no valid data; a ONE was inserted
// in_ack and underrun are combinational strobes in the tick cycle so that the
// handshake completes in the same cycle the data is sampled.
// -----------------------------------------------------------------------------
module e1_tx_liu
   import e1_pkg::*;
#(
   parameter int unsigned DIV       = 15,   // clk cycles per E1 bit, 4..255
   parameter int unsigned PULSE_LEN = 7     // pulse width in clk cycles, 1..DIV-1
)(
   input  logic clk,
   input  logic rst,
   input  logic in_data,
   input  logic in_valid,
   output logic in_ack,
   input  logic cfg_enable,
   input  logic cfg_hdb3,
   output logic tx_hi,
   output logic tx_lo,
   output logic underrun
);

   localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(PULSE_LEN - 1);

   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
   logic             tx_hi_q, tx_hi_d;
   logic             tx_lo_q, tx_lo_d;
   logic             tick;
   logic             pulse_p, pulse_n;
   sym_t             new_sym;

   // Reset gating keeps the strobes quiet while rst is held.
   assign tick     = cfg_enable && !rst && (bit_cnt_q == '0);
   assign in_ack   = tick && in_valid;
   assign underrun = tick && !in_valid;
   assign new_sym  = (in_valid ? in_data : 1'b1) ? SYM_ONE : SYM_ZERO;

   e1_tx_hdb3 u_hdb3 (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick),
      .sym_i     (new_sym),
      .hdb3_en_i (cfg_hdb3),
      .pulse_p_o (pulse_p),
      .pulse_n_o (pulse_n)
   );

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      width_cnt_d = width_cnt_q;
      tx_hi_d     = tx_hi_q;
      tx_lo_d     = tx_lo_q;

      if (!cfg_enable) begin
         // Idle: truncate any pulse and park the timer so re-enable waits DIV.
         bit_cnt_d   = DIV_M1;
         width_cnt_d = '0;
         tx_hi_d     = 1'b0;
         tx_lo_d     = 1'b0;
      end else begin
         bit_cnt_d = (bit_cnt_q == '0) ? DIV_M1 : bit_cnt_q - 1'b1;

         if (tick) begin
            tx_hi_d     = pulse_p;
            tx_lo_d     = pulse_n;
            width_cnt_d = (pulse_p || pulse_n) ? PULSE_M1 : '0;
         end else if (width_cnt_q != '0) begin
            width_cnt_d = width_cnt_q - 1'b1;
         end else begin
            tx_hi_d = 1'b0;
            tx_lo_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q   <= DIV_M1;
         width_cnt_q <= '0;
         tx_hi_q     <= 1'b0;
         tx_lo_q     <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         width_cnt_q <= width_cnt_d;
         tx_hi_q     <= tx_hi_d;
         tx_lo_q     <= tx_lo_d;
      end
   end

   assign tx_hi = tx_hi_q;
   assign tx_lo = tx_lo_q;

endmodule

// File: tb/tb_e1_tx_liu.sv
// -----------------------------------------------------------------------------
// tb_e1_tx_liu
// Self-checking bench for e1_tx_liu (DIV=15, PULSE_LEN=7). A reference model
// built from the line-coding rules (symbol queue, +1/0/-1 polarity arithmetic)
// predicts strobes and pulse levels every cycle and logs the expected line
// symbol of every tick. Directed vectors compare that log to hand-derived
// sequences; multi-cycle corners and a randomized run follow.
// -----------------------------------------------------------------------------
module tb_e1_tx_liu;

   localparam int DIV       = 15;
   localparam int PULSE_LEN = 7;

   localparam int S_ZERO = 0;
   localparam int S_ONE  = 1;
   localparam int S_B    = 2;
   localparam int S_V    = 3;
   localparam int IN_GAP = 2;   // source entry: in_valid = 0 for that tick

   logic clk = 1'b0;
   logic rst, in_data, in_valid, cfg_enable, cfg_hdb3;
   logic in_ack, tx_hi, tx_lo, underrun;

   e1_tx_liu #(.DIV(DIV), .PULSE_LEN(PULSE_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ack     (in_ack),
      .cfg_enable (cfg_enable),
      .cfg_hdb3   (cfg_hdb3),
      .tx_hi      (tx_hi),
      .tx_lo      (tx_lo),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int m_cnt, m_last, m_par, m_hi_left, m_lo_left;
   int m_pipe[$];     // [0] = next symbol onto the line
   int line_q[$];     // expected line value per tick: +1, 0, -1
   int src_q[$];      // upstream bits still to offer (0/1 or IN_GAP)
   int ack_total = 0, acc_total = 0, und_total = 0;
   bit last_ack;

   function automatic void model_reset();
      m_cnt = DIV - 1;
      m_last = -1;
      m_par = 0;
      m_hi_left = 0;
      m_lo_left = 0;
      m_pipe.delete();
      repeat (4) m_pipe.push_back(S_ZERO);
   endfunction

   task automatic drive_inputs();
      if (src_q.size() == 0) begin
         in_valid = 1'b1;
         in_data  = 1'b1;
      end else if (src_q[0] == IN_GAP) begin
         in_valid = 1'b0;
         in_data  = 1'b0;
      end else begin
         in_valid = 1'b1;
         in_data  = (src_q[0] != 0);
      end
   endtask

   // One clock cycle: compare at negedge, advance model, step inputs after posedge.
   task automatic step();
      bit tick;
      int s, pol, nsym;
      @(negedge clk);
      tick = cfg_enable && !rst && (m_cnt == 0);
      check("in_ack", int'(in_ack), int'(tick && in_valid));
      check("underrun", int'(underrun), int'(tick && !in_valid));
      check("tx_hi", int'(tx_hi), int'(m_hi_left > 0));
      check("tx_lo", int'(tx_lo), int'(m_lo_left > 0));
      check("hi_lo_exclusive", int'(tx_hi && tx_lo), 0);
      last_ack = in_ack;
      if (in_ack) ack_total++;
      if (underrun) und_total++;
      if (tick && in_valid) acc_total++;

      if (rst) begin
         model_reset();
      end else if (!cfg_enable) begin
         m_cnt = DIV - 1;
         m_hi_left = 0;
         m_lo_left = 0;
      end else if (tick) begin
         s = m_pipe.pop_front();
         pol = 0;
         if (s == S_ONE || s == S_B) begin
            pol = -m_last;
            m_last = pol;
            m_par ^= 1;
         end else if (s == S_V) begin
            pol = m_last;
            m_par = 0;
         end
         line_q.push_back(pol);
         nsym = (!in_valid || in_data) ? S_ONE : S_ZERO;
         m_pipe.push_back(nsym);
         if (cfg_hdb3 && m_pipe[0] == S_ZERO && m_pipe[1] == S_ZERO &&
             m_pipe[2] == S_ZERO && m_pipe[3] == S_ZERO) begin
            m_pipe[3] = S_V;
            m_pipe[0] = m_par ? S_ZERO : S_B;
         end
         m_hi_left = (pol > 0) ? PULSE_LEN : 0;
         m_lo_left = (pol < 0) ? PULSE_LEN : 0;
         m_cnt = DIV - 1;
      end else begin
         m_cnt--;
         if (m_hi_left > 0) m_hi_left--;
         if (m_lo_left > 0) m_lo_left--;
      end

      @(posedge clk);
      #1;
      if (tick && src_q.size() > 0) void'(src_q.pop_front());
      drive_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      src_q.delete();
      drive_inputs();
      step();
      step();
      rst = 1'b0;
      line_q.delete();
   endtask

   task automatic run_until_line(input int n, input string name);
      int budget;
      budget = (n + 2) * DIV + 10;
      while (line_q.size() < n && budget > 0) begin
         step();
         budget--;
      end
      check({name, "_timeout"}, int'(line_q.size() >= n), 1);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit hdb3;
      int n_in;
      int in_sym[8];
      int n_exp;
      int exp_line[10];
   } vec_t;

   vec_t vecs[5];

   initial begin
      int und0, ack0, gaps, run, max_run, sum, max_abs, cnt;

      vecs[0] = '{hdb3: 1'b0, n_in: 4, in_sym: '{1, 1, 1, 1, 0, 0, 0, 0},
                  n_exp: 8, exp_line: '{0, 0, 0, 0, 1, -1, 1, -1, 0, 0}};
      vecs[1] = '{hdb3: 1'b1, n_in: 5, in_sym: '{1, 0, 0, 0, 0, 0, 0, 0},
                  n_exp: 9, exp_line: '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0}};
      vecs[2] = '{hdb3: 1'b1, n_in: 6, in_sym: '{1, 1, 0, 0, 0, 0, 0, 0},
                  n_exp: 10, exp_line: '{0, 0, 0, 0, 1, -1, 1, 0, 0, 1}};
      vecs[3] = '{hdb3: 1'b1, n_in: 8, in_sym: '{0, 0, 0, 0, 0, 0, 0, 0},
                  n_exp: 9, exp_line: '{0, 1, 0, 0, 1, -1, 0, 0, -1, 0}};
      vecs[4] = '{hdb3: 1'b0, n_in: 3, in_sym: '{IN_GAP, IN_GAP, IN_GAP, 0, 0, 0, 0, 0},
                  n_exp: 7, exp_line: '{0, 0, 0, 0, 1, -1, 1, 0, 0, 0}};

      rst = 1'b1;
      in_data = 1'b0;
      in_valid = 1'b0;
      cfg_enable = 1'b1;
      cfg_hdb3 = 1'b0;
      @(posedge clk);
      #1;
      model_reset();

      // Reset state, then the table.
      for (int v = 0; v < 5; v++) begin
         cfg_hdb3 = vecs[v].hdb3;
         do_reset();
         check($sformatf("vec%0d_reset_tx", v), int'({tx_hi, tx_lo}), 0);
         for (int i = 0; i < vecs[v].n_in; i++) src_q.push_back(vecs[v].in_sym[i]);
         drive_inputs();
         gaps = 0;
         for (int i = 0; i < vecs[v].n_in; i++) if (vecs[v].in_sym[i] == IN_GAP) gaps++;
         und0 = und_total;
         ack0 = ack_total;
         run_until_line(vecs[v].n_exp, $sformatf("vec%0d", v));
         for (int i = 0; i < vecs[v].n_exp && i < line_q.size(); i++)
            check($sformatf("vec%0d_tick%0d", v, i + 1), line_q[i], vecs[v].exp_line[i]);
         check($sformatf("vec%0d_underruns", v), und_total - und0, gaps);
         check($sformatf("vec%0d_acks", v), ack_total - ack0, vecs[v].n_exp - gaps);
      end

      // HDB3 long zero run: no four consecutive spaces, bounded running sum.
      cfg_hdb3 = 1'b1;
      do_reset();
      repeat (40) src_q.push_back(0);
      drive_inputs();
      run_until_line(44, "zeros");
      run = 0; max_run = 0; sum = 0; max_abs = 0;
      foreach (line_q[i]) begin
         run = (line_q[i] == 0) ? run + 1 : 0;
         if (run > max_run) max_run = run;
         sum += line_q[i];
         if (sum > max_abs) max_abs = sum;
         if (-sum > max_abs) max_abs = -sum;
      end
      check("hdb3_zero_run_lt4", int'(max_run < 4), 1);
      check("hdb3_dc_bounded", int'(max_abs <= 2), 1);

      // Reset while tx_hi is high.
      cfg_hdb3 = 1'b0;
      do_reset();
      cnt = 0;
      while (!tx_hi && cnt < 12 * DIV) begin
         step();
         cnt++;
      end
      check("rst_pulse_seen", int'(tx_hi), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_tx_hi_cleared", int'(tx_hi), 0);
      line_q.delete();
      ack0 = ack_total;
      repeat (DIV - 1) step();
      check("rst_no_ack_window", ack_total - ack0, 0);
      run_until_line(5, "rst_next");
      if (line_q.size() >= 5) check("rst_next_mark_pos", line_q[4], 1);

      // Enable drop mid-pulse, then re-enable: first tick DIV cycles later.
      do_reset();
      cnt = 0;
      while (!tx_hi && cnt < 12 * DIV) begin
         step();
         cnt++;
      end
      check("en_pulse_seen", int'(tx_hi), 1);
      cfg_enable = 1'b0;
      step();
      check("en_tx_hi_truncated", int'(tx_hi), 0);
      repeat (20) step();
      cfg_enable = 1'b1;
      cnt = 0;
      last_ack = 1'b0;
      while (!last_ack && cnt < 2 * DIV) begin
         step();
         cnt++;
      end
      check("en_first_tick_delay", cnt, DIV);

      // Randomized traffic with mode changes and enable toggles.
      do_reset();
      for (int seg = 0; seg < 8; seg++) begin
         cfg_hdb3 = 1'($urandom_range(0, 1));
         for (int i = 0; i < 60; i++)
            src_q.push_back(($urandom_range(0, 9) == 0) ? IN_GAP : int'($urandom_range(0, 1)));
         drive_inputs();
         for (int c = 0; c < 60 * DIV; c++) begin
            step();
            if ($urandom_range(0, 199) == 0) cfg_enable = ~cfg_enable;
         end
         cfg_enable = 1'b1;
      end

      check("ack_count_vs_accepted", ack_total, acc_total);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
